// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and the fetch FSM state encoding for the instruction fetch unit.
package instruction_fetch_unit_pkg;

  localparam int          ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          INSTR_W  = 32;
  localparam int          PC_INCR  = 4;

  // IDLE: no request outstanding. WAIT: live request. DRAIN: request whose data is discarded.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetchState_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO holding fetched {pc, instr} entries. The head is read straight from
// storage flops, so an entry pushed on an edge is visible right after that edge.
// Flush is synchronous and dominates push and pop.
module fetch_fifo #(
  parameter int  WIDTH = 64,
  parameter int  DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] headData,
  output logic             headValid,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign doPop     = pop && (count != '0);
  assign doPush    = push && ((count != CNT_W'(DEPTH)) || doPop);
  assign headValid = (count != '0);
  assign headData  = mem[rdPtr];

  // Entry storage; no reset needed because count qualifies every read.
  always_ff @(posedge clk) begin
    if (doPush && !flush) mem[wrPtr] <= pushData;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues one word read at a time to instruction memory,
// buffers {pc, instr} pairs and hands them to decode. Redirects flush everything.
//
// Handshakes: imem_req/imem_ack - the request (with a stable imem_addr) is held until
// the cycle imem_ack is high, and that cycle carries imem_rdata. instr_valid/decode_ready -
// an entry transfers on every cycle both are high; while valid and not ready the head
// entry holds stable.
module instruction_fetch_unit #(
  parameter int                ADDR_W     = instruction_fetch_unit_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(instruction_fetch_unit_pkg::RESET_PC),
  parameter int                FIFO_DEPTH = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  output logic                                   imem_req,
  output logic [ADDR_W-1:0]                      imem_addr,
  input  logic                                   imem_ack,
  input  logic [31:0]                            imem_rdata,
  output logic                                   instr_valid,
  output logic [31:0]                            instr,
  output logic [ADDR_W-1:0]                      instr_pc,
  input  logic                                   decode_ready,
  input  logic                                   redirect_valid,
  input  logic [ADDR_W-1:0]                      redirect_target,
  output instruction_fetch_unit_pkg::fetchState_e fsmState
);

  import instruction_fetch_unit_pkg::*;

  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  fetchState_e        state;
  fetchState_e        stateNext;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  reqAddr;
  logic               reqQ;
  logic [CNT_W-1:0]   fifoCount;
  logic               fifoPush;
  logic               fifoPop;
  logic [ENTRY_W-1:0] headEntry;
  logic               unusedTargetLsbs;

  // Targets are word addresses; the low bits are dropped on purpose.
  assign unusedTargetLsbs = ^redirect_target[1:0];

  assign fifoPop   = instr_valid && decode_ready;
  assign imem_req  = reqQ;
  assign imem_addr = reqAddr;
  assign instr_pc  = headEntry[ENTRY_W-1:INSTR_W];
  assign instr     = headEntry[INSTR_W-1:0];
  assign fsmState  = state;

  // Next state and push decision; a redirect kills the live request's data.
  always_comb begin
    stateNext = state;
    fifoPush  = 1'b0;
    case (state)
      IDLE: begin
        if (!redirect_valid && (fifoCount < CNT_W'(FIFO_DEPTH))) stateNext = WAIT;
      end
      WAIT: begin
        if (imem_ack) begin
          stateNext = IDLE;
          fifoPush  = !redirect_valid;
        end else if (redirect_valid) begin
          stateNext = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_ack) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // State, registered request and latched request address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      reqQ    <= 1'b0;
      reqAddr <= RESET_PC;
    end else begin
      state <= stateNext;
      reqQ  <= (stateNext != IDLE);
      if (state == IDLE && stateNext == WAIT) reqAddr <= pc;
    end
  end

  // Program counter: redirect wins over sequential advance on a completed fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= {redirect_target[ADDR_W-1:2], 2'b00};
    end else if (state == WAIT && imem_ack) begin
      pc <= pc + ADDR_W'(PC_INCR);
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (fifoPush),
    .pushData  ({pc, imem_rdata}),
    .pop       (fifoPop),
    .headData  (headEntry),
    .headValid (instr_valid),
    .count     (fifoCount)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: memory responder with programmable latency, directed
// scenarios, a randomized phase, and a stream scoreboard that predicts the delivered
// {pc, instr} sequence from "sequential from the last redirect/reset" alone.
module tb_instruction_fetch_unit;

  import instruction_fetch_unit_pkg::*;

  localparam logic [31:0] RESET_PC_TB = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        decode_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  fetchState_e dbgState;

  int nCompared;
  int nMismatch;

  // Scoreboard state
  logic [63:0] exp_q[$];
  logic [31:0] streamPc;
  logic [63:0] monE;
  int          accCount;
  int          wrapCount;
  logic [31:0] lastAccPc;

  // Memory responder state
  int fixedLat;
  int curLat;
  int waitCnt;
  bit busy;
  int ackCount;

  // Monitor history
  logic        prevReq, prevAck, prevValid, prevReady, prevRedir;
  logic [31:0] prevAddr;
  logic [63:0] prevData;

  instruction_fetch_unit #(
    .ADDR_W     (32),
    .RESET_PC   (RESET_PC_TB),
    .FIFO_DEPTH (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .decode_ready    (decode_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .fsmState        (dbgState)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic void refill();
    while (exp_q.size() < 4) begin
      exp_q.push_back({streamPc, memWord(streamPc)});
      streamPc = streamPc + 32'd4;
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (imem_req) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_req_addr(input logic [31:0] a, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == a) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_req_ack(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (imem_req && imem_ack) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (instr_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_reset();
    bit ok;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    step();
    step();
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_state", 64'(dbgState), 64'(IDLE));
    exp_q.delete();
    streamPc = RESET_PC_TB;
    refill();
    ackCount = 0;
    reset    = 1'b0;
    wait_req(20, ok);
    check("rst_first_req_seen", 64'(ok), 64'd1);
    check("rst_first_addr", 64'(imem_addr), 64'(RESET_PC_TB));
  endtask

  // Memory responder: acks each request after fixedLat cycles (random 0..3 when negative).
  always @(posedge clk) begin
    #1;
    if (reset) begin
      imem_ack = 1'b0;
      busy     = 1'b0;
    end else if (imem_req) begin
      if (!busy) begin
        busy    = 1'b1;
        waitCnt = 0;
        curLat  = (fixedLat >= 0) ? fixedLat : int'($urandom_range(0, 3));
      end
      if (waitCnt == curLat) begin
        imem_ack   = 1'b1;
        imem_rdata = memWord(imem_addr);
        busy       = 1'b0;
        ackCount++;
      end else begin
        imem_ack = 1'b0;
        waitCnt++;
      end
    end else begin
      imem_ack = 1'b0;
      busy     = 1'b0;
    end
  end

  // Monitor: memory protocol, decode hold rule, and the delivered stream.
  always @(negedge clk) begin
    if (reset) begin
      prevReq   = 1'b0;
      prevAck   = 1'b0;
      prevValid = 1'b0;
      prevReady = 1'b0;
      prevRedir = 1'b0;
    end else begin
      if (prevReq && !prevAck) begin
        check("req_held", 64'(imem_req), 64'd1);
        check("addr_stable", 64'(imem_addr), 64'(prevAddr));
      end
      if (imem_req) check("addr_aligned", 64'(imem_addr & 32'h3), 64'd0);
      if (prevValid && !prevReady && !prevRedir) begin
        check("hold_valid", 64'(instr_valid), 64'd1);
        check("hold_data", {instr_pc, instr}, prevData);
      end
      if (instr_valid && decode_ready) begin
        refill();
        monE = exp_q.pop_front();
        check("stream", {instr_pc, instr}, monE);
        if (instr_pc == 32'h0 && lastAccPc == 32'hFFFF_FFFC) wrapCount++;
        lastAccPc = instr_pc;
        accCount++;
        refill();
      end
      if (redirect_valid) begin
        exp_q.delete();
        streamPc = redirect_target & ~32'h3;
        refill();
      end
      prevReq   = imem_req;
      prevAck   = imem_ack;
      prevAddr  = imem_addr;
      prevValid = instr_valid;
      prevReady = decode_ready;
      prevRedir = redirect_valid;
      prevData  = {instr_pc, instr};
    end
  end

  // Stimulus
  initial begin
    bit ok;
    int a;
    int d;
    nCompared       = 0;
    nMismatch       = 0;
    accCount        = 0;
    wrapCount       = 0;
    lastAccPc       = 32'h1;
    reset           = 1'b1;
    imem_ack        = 1'b0;
    imem_rdata      = 32'h0;
    decode_ready    = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    fixedLat        = 1;

    // Sequential fetch with a willing decoder
    decode_ready = 1'b1;
    do_reset();
    a = accCount;
    repeat (30) step();
    check("seq_progress", 64'(accCount - a >= 5), 64'd1);

    // Best-case throughput: one instruction every two cycles
    fixedLat = 0;
    do_reset();
    repeat (10) step();
    a = accCount;
    repeat (40) step();
    d = accCount - a;
    check("throughput", 64'(d >= 19 && d <= 20), 64'd1);

    // Decoder stalled: exactly two fetches, then no request
    fixedLat     = 1;
    decode_ready = 1'b0;
    do_reset();
    repeat (30) step();
    check("full_acks", 64'(ackCount), 64'd2);
    check("full_no_req", 64'(imem_req), 64'd0);
    check("full_valid", 64'(instr_valid), 64'd1);
    check("full_head_pc", 64'(instr_pc), 64'h0);
    decode_ready = 1'b1;
    a = accCount;
    repeat (20) step();
    check("full_resume", 64'(accCount - a >= 3), 64'd1);

    // Redirect while waiting on 0x8 with a slow memory
    fixedLat = 3;
    do_reset();
    wait_req_addr(32'h8, 60, ok);
    check("rd_wait8_seen", 64'(ok), 64'd1);
    step();
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    wait_req_ack(20, ok);
    check("rd_drain_ack_seen", 64'(ok), 64'd1);
    check("rd_drain_addr", 64'(imem_addr), 64'h8);
    wait_req(20, ok);
    check("rd_next_req_seen", 64'(ok), 64'd1);
    check("rd_next_addr", 64'(imem_addr), 64'h100);

    // Redirect coincident with an ack
    fixedLat = 0;
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (imem_req && imem_ack) begin ok = 1'b1; break; end
    end
    check("ra_ack_found", 64'(ok), 64'd1);
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("ra_empty", 64'(instr_valid), 64'd0);
    wait_req(20, ok);
    check("ra_next_req_seen", 64'(ok), 64'd1);
    check("ra_next_addr", 64'(imem_addr), 64'h200);

    // Redirect in the same cycle as a pop
    fixedLat     = 1;
    decode_ready = 1'b0;
    do_reset();
    wait_valid(30, ok);
    check("rp_valid_seen", 64'(ok), 64'd1);
    step();
    a               = accCount;
    decode_ready    = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0301;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("rp_empty", 64'(instr_valid), 64'd0);
    check("rp_popped", 64'(accCount - a), 64'd1);
    wait_req_addr(32'h300, 30, ok);
    check("rp_target_req", 64'(ok), 64'd1);

    // PC wrap at the top of the address space
    fixedLat  = -1;
    wrapCount = 0;
    step();
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFF9;
    step();
    redirect_valid = 1'b0;
    repeat (40) step();
    check("wrap_seen", 64'(wrapCount >= 1), 64'd1);

    // Randomized traffic
    a = accCount;
    for (int c = 0; c < 2000; c++) begin
      step();
      decode_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        redirect_valid  = 1'b1;
        redirect_target = ($urandom_range(0, 3) == 0) ?
                          (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
      end else begin
        redirect_valid = 1'b0;
      end
    end
    step();
    redirect_valid = 1'b0;
    check("rand_progress", 64'(accCount - a > 100), 64'd1);

    // Asynchronous reset in the middle of a request with one buffered entry
    fixedLat     = 6;
    decode_ready = 1'b0;
    do_reset();
    wait_valid(40, ok);
    check("mr_valid_seen", 64'(ok), 64'd1);
    wait_req(20, ok);
    check("mr_wait_seen", 64'(ok), 64'd1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("mr_req_low", 64'(imem_req), 64'd0);
    check("mr_valid_low", 64'(instr_valid), 64'd0);
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
